// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encodings,
// default memory timeout and the load-use hazard predicate.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2
  } hazState_e;

  localparam int unsigned DefaultTimeout = 64;

  // Register 0 never carries a real dependency, so a load into it is ignored.
  function automatic logic loadUse(input logic       exMemRead,
                                   input logic [4:0] exRt,
                                   input logic [4:0] idRs,
                                   input logic [4:0] idRt,
                                   input logic       idUsesRt);
    return exMemRead && (exRt != 5'd0) &&
           ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter with enable, asynchronous active-low clear and saturation at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory-wait freeze
// with a sticky timeout error, plus saturating stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IdRs,
  input  logic [4:0]       IdRt,
  input  logic             IdUsesRt,
  input  logic             ExMemRead,
  input  logic [4:0]       ExRt,
  input  logic             BranchTaken,
  input  logic             MemReq,
  input  logic             MemReady,
  output logic             PcLoad,
  output logic             IfIdLoad,
  output logic             IfIdFlush,
  output logic             IdExFlush,
  output logic             Freeze,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  hazState_e        stateQ, stateD;
  logic [WaitW-1:0] waitQ, waitD;

  logic hazard;
  logic pcLoad, ifIdLoad, ifIdFlush, idExFlush, freeze, halted;
  logic stallEn, flushEn;

  assign hazard = loadUse(ExMemRead, ExRt, IdRs, IdRt, IdUsesRt);

  always_comb begin
    stateD    = stateQ;
    waitD     = waitQ;
    pcLoad    = 1'b0;
    ifIdLoad  = 1'b0;
    ifIdFlush = 1'b0;
    idExFlush = 1'b0;
    freeze    = 1'b0;
    halted    = 1'b0;
    unique case (stateQ)
      StRun: begin
        if (MemReq && !MemReady) begin
          freeze = 1'b1;
          stateD = StMemWait;
          waitD  = WaitW'(1);
        end else if (hazard) begin
          // Branch operands are stale here; the branch re-resolves next cycle.
          idExFlush = 1'b1;
        end else if (BranchTaken) begin
          pcLoad    = 1'b1;
          ifIdLoad  = 1'b1;
          ifIdFlush = 1'b1;
        end else begin
          pcLoad   = 1'b1;
          ifIdLoad = 1'b1;
        end
      end
      StMemWait: begin
        freeze = 1'b1;
        if (MemReady) begin
          stateD = StRun;
          waitD  = '0;
        end else if (waitQ == WaitW'(TIMEOUT)) begin
          stateD = StError;
        end else begin
          waitD = waitQ + WaitW'(1);
        end
      end
      StError: begin
        freeze = 1'b1;
        halted = 1'b1;
      end
      default: begin
        stateD = StRun;
        waitD  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= StRun;
      waitQ  <= '0;
    end else begin
      stateQ <= stateD;
      waitQ  <= waitD;
    end
  end

  // Gate with reset so the controls fall to their idle values as soon as rst drops.
  assign PcLoad    = rst & pcLoad;
  assign IfIdLoad  = rst & ifIdLoad;
  assign IfIdFlush = rst & ifIdFlush;
  assign IdExFlush = rst & idExFlush;
  assign Freeze    = rst & freeze;
  assign Halted    = rst & halted;

  // ifIdFlush is only ever raised by a taken branch in RUN.
  assign stallEn = (stateQ != StError) && !pcLoad;
  assign flushEn = (stateQ == StRun) && ifIdFlush;

  sat_counter #(
    .W(CNT_W)
  ) uStallCnt (
    .clk  (clk),
    .rst  (rst),
    .en   (stallEn),
    .count(StallCount)
  );

  sat_counter #(
    .W(CNT_W)
  ) uFlushCnt (
    .clk  (clk),
    .rst  (rst),
    .en   (flushEn),
    .count(FlushCount)
  );

endmodule
